// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B - BI.
// One difference bit per clock, LSB first, through a single full-subtractor
// cell and a borrow flop. Results are registered and held between completions.
module serial_subtractor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  BI,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BO,
  output logic                  V,
  output logic                  Z,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] areg;
  logic [DATA_WIDTH-1:0] breg;
  logic [DATA_WIDTH-1:0] dreg;
  logic                  br;
  logic [CW-1:0]         cnt;
  logic                  amsb;
  logic                  bmsb;

  logic                  bit_a;
  logic                  bit_b;
  logic                  d_bit;
  logic                  br_next;
  logic [DATA_WIDTH-1:0] d_next;
  logic                  last;
  logic                  accept;

  // Full-subtractor cell on the current LSBs plus the shifted result word.
  always_comb begin
    bit_a   = areg[0];
    bit_b   = breg[0];
    d_bit   = bit_a ^ bit_b ^ br;
    br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    d_next  = {d_bit, dreg[DATA_WIDTH-1:1]};
    last    = (cnt == LAST_CNT);
    // START is only honoured while not busy; FIN accepts for back-to-back.
    accept  = START && ((state == IDLE) || (state == FIN));
  end

  // Control FSM, datapath shift registers and registered result outputs.
  // The final bit is folded straight into the outputs on the transition into
  // FIN so that DONE is visible exactly DATA_WIDTH cycles after the accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      dreg  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      D     <= '0;
      BO    <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (accept) begin
            areg  <= A;
            breg  <= B;
            br    <= BI;
            cnt   <= '0;
            dreg  <= '0;
            amsb  <= A[DATA_WIDTH-1];
            bmsb  <= B[DATA_WIDTH-1];
            BUSY  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          dreg <= d_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            D     <= d_next;
            BO    <= br_next;
            // Overflow depends only on operand signs and result sign; the
            // borrow-in cannot flip the sign relationship on its own.
            V     <= (amsb ^ bmsb) & (d_bit ^ amsb);
            Z     <= ~|d_next;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= FIN;
          end
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations against an arithmetic
// reference model of A - B - BI with borrow, overflow and zero flags.
module tb_serial_subtractor;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A, B;
  logic         BI;
  logic [W-1:0] D;
  logic         BO, V, Z, BUSY, DONE;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_d;
  logic         exp_bo, exp_v, exp_z;

  always #5 CLK = ~CLK;

  serial_subtractor #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BI(BI),
    .D(D), .BO(BO), .V(V), .Z(Z), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; bit W of the wide difference is the borrow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic v,
                       output logic z);
    logic [W:0] wide;
    wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    d  = wide[W-1:0];
    bo = wide[W];
    v  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    z  = (d == '0);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".D"},  64'(D),  64'(exp_d));
    chk({tag, ".BO"}, 64'(BO), 64'(exp_bo));
    chk({tag, ".V"},  64'(V),  64'(exp_v));
    chk({tag, ".Z"},  64'(Z),  64'(exp_z));
  endtask

  // Drive one operation, wait for DONE (bounded), check latency and results.
  // Returns #1 after the DONE edge, i.e. inside the FIN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input bit inj, input string tag);
    logic [W-1:0] md;
    logic         mbo, mv, mz;
    int           done_at;
    model(a, b, bi, md, mbo, mv, mz);
    START = 1'b1; A = a; B = b; BI = bi;
    @(posedge CLK); #1;
    START = 1'b0; A = $urandom; B = $urandom; BI = 1'($urandom);
    chk({tag, ".busy0"}, 64'(BUSY), 64'(1));
    chk({tag, ".done0"}, 64'(DONE), 64'(0));
    done_at = 0;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge CLK); #1;
      if (inj && c == 5) begin START = 1'b1; A = 1; B = 1; BI = 1'b0; end
      if (inj && c == 6) START = 1'b0;
      if (DONE) begin done_at = c; break; end
      if (c == W / 2) begin
        chk({tag, ".midbusy"}, 64'(BUSY), 64'(1));
        check_outputs({tag, ".hold"});
      end
    end
    START = 1'b0;
    chk({tag, ".latency"}, 64'(done_at), 64'(W));
    exp_d = md; exp_bo = mbo; exp_v = mv; exp_z = mz;
    if (done_at != 0) begin
      chk({tag, ".busyfin"}, 64'(BUSY), 64'(0));
      check_outputs(tag);
    end
  endtask

  task automatic idle_gap(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      chk({tag, ".gapdone"}, 64'(DONE), 64'(0));
      chk({tag, ".gapbusy"}, 64'(BUSY), 64'(0));
      check_outputs({tag, ".gap"});
    end
  endtask

  initial begin
    bit seen_done;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; BI = 1'b0;
    exp_d = '0; exp_bo = 1'b0; exp_v = 1'b0; exp_z = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset");
    chk("reset.BUSY", 64'(BUSY), 64'(0));
    chk("reset.DONE", 64'(DONE), 64'(0));
    RST = 1'b0;
    idle_gap(1, "post_reset");

    // Directed cases
    do_op(32'd10, 32'd3, 1'b0, 0, "sub10_3");           idle_gap(1, "g1");
    do_op(32'd3, 32'd10, 1'b0, 0, "sub3_10");           idle_gap(1, "g2");
    do_op(32'h8000_0000, 32'd1, 1'b0, 0, "ovf_neg");    idle_gap(1, "g3");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf_pos"); idle_gap(1, "g4");
    do_op(32'd5, 32'd4, 1'b1, 0, "zero_bi");            idle_gap(1, "g5");
    do_op(32'd0, 32'd0, 1'b1, 0, "all_ones");           idle_gap(2, "g6");
    do_op(32'd100, 32'd1, 1'b0, 1, "start_ignored");    idle_gap(1, "g7");

    // Reset in the middle of a run, with START asserted alongside RST
    START = 1'b1; A = 32'd200; B = 32'd50; BI = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; START = 1'b0;
    exp_d = '0; exp_bo = 1'b0; exp_v = 1'b0; exp_z = 1'b0;
    check_outputs("midrst");
    chk("midrst.BUSY", 64'(BUSY), 64'(0));
    chk("midrst.DONE", 64'(DONE), 64'(0));
    seen_done = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen_done = 1'b1;
    end
    chk("midrst.nodone", 64'(seen_done), 64'(0));

    // Back-to-back: second START presented during the DONE cycle
    do_op(32'd10, 32'd3, 1'b0, 0, "b2b_first");
    do_op(32'd20, 32'd5, 1'b0, 0, "b2b_second");
    idle_gap(1, "g8");

    // Random operations with random idle gaps (0 = back-to-back)
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (n % 5 == 0) ? ra : $urandom;
      do_op(ra, rb, 1'($urandom), 0, "rand");
      idle_gap(int'($urandom_range(0, 2)), "rgap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
